// File: rtl/line_shift_buf_multi.sv
// N-line pixel shift buffer: current pixel plus co-located pixels from the previous NUM_TAPS lines.
// Optional LSB_EDGE_REPLICATE_EN: unfilled taps replicate the nearest filled line instead of reading 0.
module line_shift_buf_multi #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int ADDR_W    = 10,
    parameter int NUM_TAPS  = 2
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       per_frame_vsync,
    input  logic                       per_frame_href,
    input  logic                       clken,
    input  logic [DATA_W-1:0]          shiftin,
    output logic                       taps_valid,
    output logic [DATA_W-1:0]          row_cur,
    output logic [DATA_W*NUM_TAPS-1:0] taps,
    output logic [3:0]                 lines_filled,
    output logic                       overflow
);

    // RAM depth follows the address width so any column index stays in range.
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAX_WIDTH - 1);
    localparam logic [3:0]        FILL_MAX = 4'(NUM_TAPS);

    logic accept;
    logic vsync_rise;
    logic href_fall;

    logic                   vsync_q, vsync_d;
    logic                   href_q, href_d;
    logic [ADDR_W-1:0]      col_q, col_d;
    logic                   line_full_q, line_full_d;
    logic                   line_acc_q, line_acc_d;
    logic [3:0]             lines_filled_q, lines_filled_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      row_cur_q, row_cur_d;
    logic [3:0]             fill_at_q, fill_at_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] rd_q, rd_d;

    always_comb begin
        accept     = clken & per_frame_href;
        vsync_rise = per_frame_vsync & ~vsync_q;
        href_fall  = href_q & ~per_frame_href;
        vsync_d    = per_frame_vsync;
        href_d     = per_frame_href;

        col_d       = col_q;
        line_full_d = line_full_q;
        if (!per_frame_href) begin
            col_d       = '0;
            line_full_d = 1'b0;
        end else if (accept) begin
            // Column saturates on the last slot; the next accept is the overflow.
            if (col_q == COL_LAST) line_full_d = 1'b1;
            else                   col_d       = col_q + 1'b1;
        end

        line_acc_d = line_acc_q;
        if (href_fall)   line_acc_d = 1'b0;
        else if (accept) line_acc_d = 1'b1;

        lines_filled_d = lines_filled_q;
        if (vsync_rise)
            lines_filled_d = 4'd0;
        else if (href_fall && line_acc_q && lines_filled_q != FILL_MAX)
            lines_filled_d = lines_filled_q + 4'd1;

        overflow_d = overflow_q;
        if (vsync_rise)                 overflow_d = 1'b0;
        else if (accept && line_full_q) overflow_d = 1'b1;

        valid_d   = accept;
        row_cur_d = accept ? shiftin : row_cur_q;
        fill_at_d = accept ? lines_filled_q : fill_at_q;
        wr_en_d   = accept & ~line_full_q;
        wr_addr_d = accept ? col_q : wr_addr_q;
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] wr_data;

        if (k == 0) begin : g_first
            assign wr_data = row_cur_q;
        end else begin : g_chain
            assign wr_data = rd_q[k-1];
        end

        always_ff @(posedge clock) begin
            if (wr_en_q) mem[wr_addr_q] <= wr_data;
        end

        assign rd_d[k] = accept ? mem[col_q] : rd_q[k];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            col_q          <= '0;
            line_full_q    <= 1'b0;
            line_acc_q     <= 1'b0;
            lines_filled_q <= 4'd0;
            overflow_q     <= 1'b0;
            valid_q        <= 1'b0;
            row_cur_q      <= '0;
            fill_at_q      <= 4'd0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            rd_q           <= '0;
        end else begin
            vsync_q        <= vsync_d;
            href_q         <= href_d;
            col_q          <= col_d;
            line_full_q    <= line_full_d;
            line_acc_q     <= line_acc_d;
            lines_filled_q <= lines_filled_d;
            overflow_q     <= overflow_d;
            valid_q        <= valid_d;
            row_cur_q      <= row_cur_d;
            fill_at_q      <= fill_at_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            rd_q           <= rd_d;
        end
    end

    // Fill mask uses the line count captured with the pixel, not the live one.
    always_comb begin
        taps = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (fill_at_q > 4'(k)) begin
                taps[k*DATA_W +: DATA_W] = rd_q[k];
            end else begin
`ifdef LSB_EDGE_REPLICATE_EN
                taps[k*DATA_W +: DATA_W] = row_cur_q;
                for (int j = 0; j < k; j++) begin
                    if (fill_at_q > 4'(j)) taps[k*DATA_W +: DATA_W] = rd_q[j];
                end
`else
                taps[k*DATA_W +: DATA_W] = '0;
`endif
            end
        end
    end

    assign taps_valid   = valid_q;
    assign row_cur      = row_cur_q;
    assign lines_filled = lines_filled_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_line_shift_buf_multi.sv
// Scoreboard bench for line_shift_buf_multi (DATA_W=8, MAX_WIDTH=8, ADDR_W=3, NUM_TAPS=2).
module tb_line_shift_buf_multi;

    localparam int DW = 8;
    localparam int MW = 8;
    localparam int AW = 3;
    localparam int NT = 2;

    logic            clock = 1'b0;
    logic            rst_n = 1'b0;
    logic            vsync = 1'b0;
    logic            href  = 1'b0;
    logic            clken = 1'b0;
    logic [DW-1:0]   shiftin = '0;
    logic            taps_valid;
    logic [DW-1:0]   row_cur;
    logic [DW*NT-1:0] taps;
    logic [3:0]      lines_filled;
    logic            overflow;

    line_shift_buf_multi #(
        .DATA_W(DW), .MAX_WIDTH(MW), .ADDR_W(AW), .NUM_TAPS(NT)
    ) dut (
        .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync),
        .per_frame_href(href), .clken(clken), .shiftin(shiftin),
        .taps_valid(taps_valid), .row_cur(row_cur), .taps(taps),
        .lines_filled(lines_filled), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0]    row;
        logic [DW*NT-1:0] tp;
        logic             ovf;
        bit               chk_taps;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] hist [NT][MW];
    logic [DW-1:0] cur  [MW];
    int  fill  = 0;
    bit  m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid output pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_n && taps_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("row_cur", 32'(row_cur), 32'(e.row));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    if (e.chk_taps) check("taps", 32'(taps), 32'(e.tp));
                end
            end
        end
    end

    task automatic cyc(input bit h, input bit ce, input logic [DW-1:0] px);
        @(negedge clock);
        href = h; clken = ce; shiftin = px;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic push_pix(input int p, input logic [DW-1:0] px);
        exp_t e;
        int col;
        logic [DW-1:0] t;
        col = (p < MW) ? p : MW - 1;
        if (p >= MW) m_ovf = 1'b1;
        e.row = px;
        e.ovf = m_ovf;
        e.chk_taps = (p < MW);
        e.tp = '0;
        for (int k = 0; k < NT; k++) begin
            if (fill > k) begin
                t = hist[k][col];
            end else begin
`ifdef LSB_EDGE_REPLICATE_EN
                t = px;
                for (int j = 0; j < k; j++) if (fill > j) t = hist[j][col];
`else
                t = '0;
`endif
            end
            e.tp[k*DW +: DW] = t;
        end
        if (p < MW) cur[p] = px;
        cyc(1'b1, 1'b1, px);
        sb.push_back(e);
    endtask

    task automatic send_line(input logic [DW-1:0] base, input int n, input bit gap);
        for (int p = 0; p < n; p++) begin
            push_pix(p, 8'(base + p));
            if (gap) cyc(1'b1, 1'b0, '0);
        end
        cyc(1'b0, 1'b0, '0);
        for (int c = 0; c < MW && c < n; c++) begin
            for (int k = NT - 1; k > 0; k--) hist[k][c] = hist[k-1][c];
            hist[0][c] = cur[c];
        end
        if (fill < NT) fill++;
    endtask

    task automatic vsync_pulse();
        @(negedge clock); vsync = 1'b1; href = 1'b0; clken = 1'b0;
        @(negedge clock);
        @(negedge clock); vsync = 1'b0;
        fill = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        int lf_exp [4];
        lf_exp = '{1, 2, 2, 2};
        for (int k = 0; k < NT; k++) for (int c = 0; c < MW; c++) hist[k][c] = '0;
        for (int c = 0; c < MW; c++) cur[c] = '0;

        // Reset and idle
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        check("rst_valid", 32'(taps_valid), 32'd0);
        check("rst_row", 32'(row_cur), 32'd0);
        check("rst_taps", 32'(taps), 32'd0);
        check("rst_lines", 32'(lines_filled), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_valid", 32'(taps_valid), 32'd0);
        end

        // Four full lines, pixel = line*16 + col
        for (int l = 0; l < 4; l++) begin
            send_line(8'(l * 16), 8, 1'b0);
            idle(1);
            check("lines_filled", 32'(lines_filled), 32'(lf_exp[l]));
        end

        // Gapped clken, partial line of three pixels
        send_line(8'h40, 3, 1'b1);
        idle(1);
        check("lines_gap", 32'(lines_filled), 32'd2);

        // Overflow line of 10, then a line reading back the first 8
        send_line(8'h50, 10, 1'b0);
        idle(1);
        check("ovf_set", 32'(overflow), 32'd1);
        send_line(8'h60, 8, 1'b0);
        idle(1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // New frame
        check("pre_vsync_lines", 32'(lines_filled), 32'd2);
        vsync_pulse();
        idle(1);
        check("vsync_lines", 32'(lines_filled), 32'd0);
        check("vsync_ovf", 32'(overflow), 32'd0);
        send_line(8'hA0, 8, 1'b0);
        send_line(8'hB0, 8, 1'b0);
        send_line(8'hC0, 8, 1'b0);
        idle(1);

        // Reset in the middle of a line
        for (int p = 0; p < 5; p++) push_pix(p, 8'(8'hD0 + p));
        cyc(1'b1, 1'b0, '0);
        check("pre_rst_drain", 32'(sb.size()), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(taps_valid), 32'd0);
        check("mrst_row", 32'(row_cur), 32'd0);
        check("mrst_taps", 32'(taps), 32'd0);
        check("mrst_lines", 32'(lines_filled), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        href = 1'b0; clken = 1'b0;
        fill = 0;
        m_ovf = 1'b0;
        sb.delete();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        send_line(8'h70, 8, 1'b0);
        send_line(8'h80, 8, 1'b0);
        idle(2);
        check("final_lines", 32'(lines_filled), 32'd2);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
